// File: rtl/wb_arb_rr_param.sv
// rtl/wb_arb_rr_param.sv - parametrised round-robin Wishbone bus arbiter
// Rotating priority from the last winner, optional hold limit applied at transfer boundaries.
module wb_arb_rr_param #(
    parameter int  NM        = 4,
    parameter int  MAX_HOLD  = 0,
    parameter bit  PARK_LAST = 1'b1,
    localparam int GW        = $clog2(NM)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [NM-1:0] req,
    input  logic          ack_done,
    output logic [GW-1:0] gnt,
    output logic [NM-1:0] gnt_oh,
    output logic          grant_vld,
    output logic [15:0]   hold_cnt
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_BUSY  = 1'b1;
    localparam logic [GW-1:0] PTR_RST  = GW'(NM - 1);
    localparam logic [15:0]   HOLD_LIM = 16'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam bit            HOLD_EN  = (MAX_HOLD != 0);

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [NM-1:0] gnt_oh_q, gnt_oh_d;
    logic [15:0]   hold_q, hold_d;

    logic [GW:0]   pick_idle;
    logic [GW:0]   pick_next;
    logic          own_req;
    logic          other_req;

    // Returns {found, index} of the nearest requester at distance 1..span after base;
    // distance NM means base itself, so span=NM-1 never returns to base.
    function automatic logic [GW:0] rr_pick(input logic [NM-1:0] r,
                                            input logic [GW-1:0] base,
                                            input int            span);
        logic [GW:0] res;
        int          best;
        int          d;
        res  = '0;
        best = NM + 1;
        for (int i = 0; i < NM; i++) begin
            d = i - int'(base);
            if (d <= 0) d = d + NM;
            if (r[i] && (d <= span) && (d < best)) begin
                best = d;
                res  = {1'b1, GW'(i)};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_oh_d  = '0;
        pick_idle = rr_pick(req, ptr_q, NM);
        pick_next = rr_pick(req, gnt_q, NM - 1);
        own_req   = |(req & gnt_oh_q);
        other_req = |(req & ~gnt_oh_q);

        if (state_q == ST_IDLE) begin
            hold_d = '0;
            if (pick_idle[GW]) begin
                state_d = ST_BUSY;
                gnt_d   = pick_idle[GW-1:0];
                ptr_d   = pick_idle[GW-1:0];
            end else if (!PARK_LAST) begin
                gnt_d = '0;
            end
        end else if (!own_req) begin
            // Owner released: hand over without an idle gap when anyone else waits
            hold_d = '0;
            if (pick_next[GW]) begin
                gnt_d = pick_next[GW-1:0];
                ptr_d = pick_next[GW-1:0];
            end else begin
                state_d = ST_IDLE;
                if (!PARK_LAST) gnt_d = '0;
            end
        end else if (HOLD_EN && (hold_q >= HOLD_LIM) && ack_done && other_req) begin
            hold_d = '0;
            gnt_d  = pick_next[GW-1:0];
            ptr_d  = pick_next[GW-1:0];
        end else if (hold_q != 16'hFFFF) begin
            hold_d = hold_q + 16'd1;
        end

        for (int i = 0; i < NM; i++) begin
            gnt_oh_d[i] = (state_d == ST_BUSY) && (gnt_d == GW'(i));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ptr_q    <= PTR_RST;
            gnt_oh_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            gnt_oh_q <= gnt_oh_d;
            hold_q   <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_oh    = gnt_oh_q;
    assign grant_vld = (state_q == ST_BUSY);
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_wb_arb_rr_param.sv
// tb/tb_wb_arb_rr_param.sv - scoreboard bench for wb_arb_rr_param
// Two instances: unlimited hold with parking, and MAX_HOLD=4 without parking.
module tb_wb_arb_rr_param;

    localparam int NM = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic        ack_done;

    logic [1:0]  g0, g1;
    logic [3:0]  oh0, oh1;
    logic        v0, v1;
    logic [15:0] h0, h1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    wb_arb_rr_param #(.NM(4), .MAX_HOLD(0), .PARK_LAST(1'b1)) u0 (
        .clk(clk), .rstn(rstn), .req(req), .ack_done(ack_done),
        .gnt(g0), .gnt_oh(oh0), .grant_vld(v0), .hold_cnt(h0)
    );

    wb_arb_rr_param #(.NM(4), .MAX_HOLD(4), .PARK_LAST(1'b0)) u1 (
        .clk(clk), .rstn(rstn), .req(req), .ack_done(ack_done),
        .gnt(g1), .gnt_oh(oh1), .grant_vld(v1), .hold_cnt(h1)
    );

    typedef struct {
        int inst;
        int gnt;
        int vld;
        int hold;
        int cyc;
    } exp_t;

    exp_t sb[$];

    int m_vld[2];
    int m_gnt[2];
    int m_ptr[2];
    int m_hold[2];
    int m_maxh[2] = '{0, 4};
    int m_park[2] = '{1, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vld[i]  = 0;
            m_gnt[i]  = 0;
            m_ptr[i]  = NM - 1;
            m_hold[i] = 0;
        end
    endtask

    // First requesting master among start, start+1, ... (cnt masters, wrapping); -1 if none
    function automatic int first_req(input logic [3:0] r, input int start, input int cnt);
        int idx;
        for (int k = 0; k < cnt; k++) begin
            idx = (start + k) % NM;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input int i, input logic [3:0] r, input logic a);
        int w;
        if (m_vld[i] == 0) begin
            w = first_req(r, (m_ptr[i] + 1) % NM, NM);
            m_hold[i] = 0;
            if (w >= 0) begin
                m_vld[i] = 1;
                m_gnt[i] = w;
                m_ptr[i] = w;
            end else if (m_park[i] == 0) begin
                m_gnt[i] = 0;
            end
        end else begin
            w = first_req(r, (m_gnt[i] + 1) % NM, NM - 1);
            if (!r[m_gnt[i]]) begin
                m_hold[i] = 0;
                if (w >= 0) begin
                    m_gnt[i] = w;
                    m_ptr[i] = w;
                end else begin
                    m_vld[i] = 0;
                    if (m_park[i] == 0) m_gnt[i] = 0;
                end
            end else if (m_maxh[i] != 0 && m_hold[i] >= m_maxh[i] - 1 && a && w >= 0) begin
                m_hold[i] = 0;
                m_gnt[i]  = w;
                m_ptr[i]  = w;
            end else if (m_hold[i] < 65535) begin
                m_hold[i] = m_hold[i] + 1;
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic a);
        exp_t e;
        @(negedge clk);
        req      = r;
        ack_done = a;
        for (int i = 0; i < 2; i++) begin
            model_step(i, r, a);
            e.inst = i;
            e.gnt  = m_gnt[i];
            e.vld  = m_vld[i];
            e.hold = m_hold[i];
            e.cyc  = cyc;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic expect_gnt0(input string name, input int exp);
        @(posedge clk);
        #1;
        check(name, 32'(g0), 32'(exp));
    endtask

    initial begin : monitor
        exp_t        e;
        logic [3:0]  eoh;
        logic [22:0] ev;
        logic [22:0] av;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                eoh = (e.vld != 0) ? (4'b0001 << e.gnt) : 4'b0000;
                ev  = {2'(e.gnt), eoh, (e.vld != 0), 16'(e.hold)};
                av  = (e.inst == 0) ? {g0, oh0, v0, h0} : {g1, oh1, v1, h1};
                check($sformatf("u%0d cyc%0d {gnt,oh,vld,hold}", e.inst, e.cyc),
                      32'(av), 32'(ev));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] r;
        rstn     = 1'b0;
        req      = 4'b0000;
        ack_done = 1'b0;
        model_reset();
        #2;
        check("reset u0", 32'({g0, oh0, v0, h0}), 32'd0);
        check("reset u1", 32'({g1, oh1, v1, h1}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // All request, ack pulsing: u0 never rotates
        repeat (8) drive(4'b1111, 1'b1);

        // Drop and wrap sequence
        drive(4'b0010, 1'b0);
        expect_gnt0("u0 gnt after req=0010", 1);
        drive(4'b0111, 1'b0);
        drive(4'b0101, 1'b0);
        expect_gnt0("u0 gnt after req[1] drop", 2);
        drive(4'b0001, 1'b0);
        expect_gnt0("u0 gnt wrap to 0", 0);

        // Each owner drops for one cycle while all others request
        for (int j = 0; j < 8; j++) begin
            drive(4'b1111, 1'b0);
            drive(4'b1111 & ~(4'b0001 << m_gnt[0]), 1'b0);
        end

        // Hold limit with ack every cycle, then with ack held off
        repeat (16) drive(4'b0011, 1'b1);
        repeat (10) drive(4'b0011, 1'b0);
        repeat (3)  drive(4'b0011, 1'b1);

        // Idle parking
        repeat (3) drive(4'b0000, 1'b0);
        drive(4'b0100, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);

        // Randomised traffic
        for (int j = 0; j < 400; j++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            drive(r, 1'($urandom_range(0, 1)));
        end

        // Reset while busy, then single request from master 3
        repeat (3) drive(4'b1111, 1'b1);
        @(negedge clk);
        req      = 4'b0000;
        ack_done = 1'b0;
        rstn     = 1'b0;
        #1;
        check("mid-busy reset u0", 32'({g0, oh0, v0, h0}), 32'd0);
        check("mid-busy reset u1", 32'({g1, oh1, v1, h1}), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        drive(4'b1000, 1'b0);
        expect_gnt0("u0 gnt after reset req=1000", 3);
        check("u1 gnt after reset req=1000", 32'(g1), 32'd3);
        repeat (2) drive(4'b0000, 1'b0);

        @(posedge clk);
        #2;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
